// File: rtl/rv32i_pkg.sv
// Shared RV32I store-path definitions: store type encodings and the
// buffered write entry layout.
package rv32i_pkg;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // One buffered store: word address, lane-aligned data, byte strobes.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } st_entry_t;

  // Expand a stored word address back to a byte address on a word boundary.
  function automatic logic [31:0] word_to_byte(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/store_align_rv32i.sv
// Byte-lane placement and strobe generation for SB/SH/SW, with
// misalignment / illegal-type detection. Purely combinational.
module store_align_rv32i
  import rv32i_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  store_type_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        misaligned_o
);

  // Select lane placement by access size; anything not naturally aligned,
  // and the unused funct3 encoding, is flagged and produces no strobes.
  always_comb begin
    wdata_o      = '0;
    wstrb_o      = '0;
    misaligned_o = 1'b0;
    case (store_type_i)
      ST_SB: begin
        wdata_o = {24'h0, data_i[7:0]} << {off_i, 3'b000};
        wstrb_o = 4'b0001 << off_i;
      end
      ST_SH: begin
        if (off_i[0]) begin
          misaligned_o = 1'b1;
        end else if (off_i[1]) begin
          wdata_o = {data_i[15:0], 16'h0};
          wstrb_o = 4'b1100;
        end else begin
          wdata_o = {16'h0, data_i[15:0]};
          wstrb_o = 4'b0011;
        end
      end
      ST_SW: begin
        if (off_i != 2'b00) begin
          misaligned_o = 1'b1;
        end else begin
          wdata_o = data_i;
          wstrb_o = 4'b1111;
        end
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit_rv32i.sv
// RV32I store unit: aligns store requests, drops misaligned/illegal ones
// with a one-cycle misalign pulse, and queues legal stores in an in-order
// buffer drained to data memory over a valid/ready write port.
module store_unit_rv32i
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  store_type,
  output logic        misalign,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic        idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  st_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       al_wdata;
  logic [3:0]        al_wstrb;
  logic              al_bad;
  logic              accept, enq, deq;
  st_entry_t         head, entry_in;

  store_align_rv32i u_align (
    .off_i        (req_addr[1:0]),
    .store_type_i (store_type),
    .data_i       (req_data),
    .wdata_o      (al_wdata),
    .wstrb_o      (al_wstrb),
    .misaligned_o (al_bad)
  );

  // Handshake and queue control; req_ready looks only at the registered
  // count, so a same-cycle dequeue never frees a slot for this accept.
  always_comb begin
    req_ready  = (count_q < DEPTH_C);
    accept     = req_valid && req_ready;
    enq        = accept && !al_bad;
    deq        = (count_q != '0) && dmem_ready;
    misalign_d = accept && al_bad;
    wptr_d     = enq ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = deq ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    entry_in.addr  = req_addr[31:2];
    entry_in.wdata = al_wdata;
    entry_in.wstrb = al_wstrb;
  end

  // Pointer, occupancy and misalign-pulse registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wptr_q] <= entry_in;
    end
  end

  // Head entry drives the write port; payload is forced to zero when empty
  // so the port reads clean after reset without resetting storage.
  always_comb begin
    head       = mem_q[rptr_q];
    dmem_valid = (count_q != '0);
    idle       = (count_q == '0);
    misalign   = misalign_q;
    dmem_addr  = dmem_valid ? word_to_byte(head.addr) : '0;
    dmem_wdata = dmem_valid ? head.wdata : '0;
    dmem_wstrb = dmem_valid ? head.wstrb : '0;
  end

endmodule

// File: tb/tb_store_unit_rv32i.sv
// Directed bench for store_unit_rv32i (DEPTH=2).
module tb_store_unit_rv32i;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  store_type;
  logic        misalign;
  logic        dmem_valid;
  logic        dmem_ready;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        idle;

  int total = 0;
  int bad   = 0;

  store_unit_rv32i #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .store_type (store_type),
    .misalign   (misalign),
    .dmem_valid (dmem_valid),
    .dmem_ready (dmem_ready),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    store_type = t;
    req_addr   = a;
    req_data   = d;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    chk({tag, "_valid"}, {31'h0, dmem_valid}, 32'h1);
    chk({tag, "_addr"},  dmem_addr,  a);
    chk({tag, "_wdata"}, dmem_wdata, d);
    chk({tag, "_wstrb"}, {28'h0, dmem_wstrb}, {28'h0, s});
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #2;
    chk("rst_valid",  {31'h0, dmem_valid}, 32'h0);
    chk("rst_idle",   {31'h0, idle},       32'h1);
    chk("rst_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_mis",    {31'h0, misalign},   32'h0);
    chk("rst_addr",   dmem_addr,  32'h0);
    chk("rst_wdata",  dmem_wdata, 32'h0);
    chk("rst_wstrb",  {28'h0, dmem_wstrb}, 32'h0);
    rst = 1'b0;

    // SB to the top byte lane, drained immediately
    dmem_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk_head("sb", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
    chk("sb_idle0", {31'h0, idle}, 32'h0);
    chk("sb_mis",   {31'h0, misalign}, 32'h0);
    tick();
    chk("sb_idle1",  {31'h0, idle},       32'h1);
    chk("sb_valid0", {31'h0, dmem_valid}, 32'h0);

    // SH upper half then SW, queued with memory stalled
    dmem_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0000_2002, 32'h1234_BEEF);
    tick();
    drive(1'b1, 2'b10, 32'h0000_2004, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk_head("sh", 32'h0000_2000, 32'hBEEF_0000, 4'b1100);
    chk("full_ready", {31'h0, req_ready}, 32'h0);
    dmem_ready = 1'b1;
    tick();
    chk_head("sw", 32'h0000_2004, 32'hCAFE_F00D, 4'b1111);
    tick();
    chk("shsw_idle", {31'h0, idle}, 32'h1);

    // Misaligned SH, misaligned SW, illegal type: each a one-cycle pulse
    drive(1'b1, 2'b01, 32'h0000_3001, 32'h5555_5555);
    tick();
    drive(1'b1, 2'b10, 32'h0000_3002, 32'h6666_6666);
    chk("mis_sh",       {31'h0, misalign},   32'h1);
    chk("mis_sh_valid", {31'h0, dmem_valid}, 32'h0);
    chk("mis_sh_idle",  {31'h0, idle},       32'h1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("mis_sw",       {31'h0, misalign},   32'h1);
    chk("mis_sw_valid", {31'h0, dmem_valid}, 32'h0);
    tick();
    chk("mis_clear", {31'h0, misalign}, 32'h0);
    drive(1'b1, 2'b11, 32'h0000_3000, 32'h7777_7777);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("ill_mis",  {31'h0, misalign}, 32'h1);
    chk("ill_idle", {31'h0, idle},     32'h1);
    tick();

    // Full buffer backpressure and in-order drain
    dmem_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h0000_4000, 32'h1111_1111);
    tick();
    drive(1'b1, 2'b10, 32'h0000_4004, 32'h2222_2222);
    chk("bp_ready1", {31'h0, req_ready}, 32'h1);
    tick();
    drive(1'b1, 2'b10, 32'h0000_4008, 32'h3333_3333);
    chk("bp_ready0", {31'h0, req_ready}, 32'h0);
    chk_head("bp_h1a", 32'h0000_4000, 32'h1111_1111, 4'b1111);
    tick();
    chk("bp_hold_ready", {31'h0, req_ready}, 32'h0);
    chk_head("bp_h1b", 32'h0000_4000, 32'h1111_1111, 4'b1111);
    dmem_ready = 1'b1;
    tick();
    chk_head("bp_h2", 32'h0000_4004, 32'h2222_2222, 4'b1111);
    chk("bp_ready_again", {31'h0, req_ready}, 32'h1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk_head("bp_h3", 32'h0000_4008, 32'h3333_3333, 4'b1111);
    tick();
    chk("bp_idle", {31'h0, idle}, 32'h1);

    // Simultaneous enqueue and dequeue keeps one entry
    drive(1'b1, 2'b00, 32'h0000_5000, 32'h0000_005A);
    tick();
    drive(1'b1, 2'b00, 32'h0000_5001, 32'h0000_006B);
    chk_head("ed_h1", 32'h0000_5000, 32'h0000_005A, 4'b0001);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk_head("ed_h2", 32'h0000_5000, 32'h0000_6B00, 4'b0010);
    chk("ed_ready", {31'h0, req_ready}, 32'h1);
    tick();
    chk("ed_idle", {31'h0, idle}, 32'h1);

    // Misaligned accept together with a dequeue
    drive(1'b1, 2'b10, 32'h0000_6000, 32'h0000_0077);
    tick();
    drive(1'b1, 2'b01, 32'h0000_6003, 32'h0000_0088);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("md_mis",  {31'h0, misalign}, 32'h1);
    chk("md_idle", {31'h0, idle},     32'h1);
    tick();

    // Asynchronous reset with two pending stores
    dmem_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h0000_7000, 32'hAAAA_AAAA);
    tick();
    drive(1'b1, 2'b10, 32'h0000_7004, 32'hBBBB_BBBB);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("ar_pre_valid", {31'h0, dmem_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'h0, dmem_valid}, 32'h0);
    chk("ar_idle",  {31'h0, idle},       32'h1);
    chk("ar_ready", {31'h0, req_ready},  32'h1);
    chk("ar_addr",  dmem_addr, 32'h0);
    #3;
    rst = 1'b0;
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_after_valid", {31'h0, dmem_valid}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_unit_rv32i.md
# store_unit_rv32i

Store-side counterpart of the load data path. Takes SB/SH/SW requests from the execute/memory stage, places the store data on the correct byte lanes of a 32-bit word, generates byte strobes, and detects misaligned or illegal stores. Legal stores are held in a small in-order buffer and sent to data memory over a valid/ready write port, so pipeline stalls only occur when the buffer is full.

## Interface
Parameters:
- DEPTH, 2, number of buffered stores (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request this cycle
- req_addr  in  32  byte address
- req_data  in  32  rs2 value, unaligned (LSB-justified)
- store_type  in  2  funct3[1:0]: 00 SB, 01 SH, 10 SW, 11 illegal
- misalign  out  1  one-cycle pulse: the last accepted request was dropped
- dmem_valid  out  1  write request to data memory
- dmem_ready  in  1  data memory accepts the write
- dmem_addr  out  32  word address, {req_addr[31:2], 2'b00}
- dmem_wdata  out  32  lane-aligned write data
- dmem_wstrb  out  4  byte enables, bit i = byte lane i
- idle  out  1  buffer empty; used for fence/drain

## Operation
- Accept on a cycle where req_valid && req_ready. Req_ready = (count < DEPTH). A dequeue in the same cycle does not free a slot for that cycle's accept.
- Alignment is selected by off = req_addr[1:0]:
  - SB: wdata = req_data[7:0] << 8·off, other lanes 0; wstrb = 4'b0001 << off; always legal.
  - SH: legal only if off[0]=0. wdata = req_data[15:0] << 16·off[1]; wstrb = 0011 (off=00) or 1100 (off=10).
  - SW: legal only if off=00. wdata = req_data; wstrb = 1111.
  - type 11: illegal.
- An illegal or misaligned request is still handshaken (consumed) but is not enqueued. Misalign is high for exactly the one cycle after the accepting edge.
- Legal requests are enqueued as {word addr, wdata, wstrb}. The buffer is FIFO; order is preserved and nothing is merged or coalesced.
- dmem_valid = !empty. dmem_addr, dmem_wdata and dmem_wstrb come from the head entry.
- A dequeue happens when dmem_valid && dmem_ready.
- Once dmem_valid is raised, it and the head payload stay stable until the dequeue.
- Enqueue and dequeue in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- idle = (count == 0).

## Timing
- Reset values: count=0, read/write pointers=0, misalign=0, dmem_valid=0, dmem_addr/wdata/wstrb=0, idle=1, req_ready=1.
- Latency: a legal store accepted at edge N gives dmem_valid=1 in the cycle after edge N, with its payload, if the buffer was empty. Otherwise it waits behind the earlier entries.
- Throughput: one store per cycle when dmem_ready stays high.
- Full buffer: req_ready=0. A held request is accepted in the cycle after the first dequeue.
- A misaligned accept and a dequeue may occur in the same cycle; count decrements only.
- Reset mid-operation drops all buffered stores immediately (asynchronous). dmem_valid falls without a handshake.
- The outputs are not combinationally dependent on req_* or dmem_ready, except req_ready, which depends only on count.

## Structure
- Shared package rv32i_pkg contains:
  - store type constants ST_SB=2'b00, ST_SH=2'b01, ST_SW=2'b10;
  - the entry struct {addr[31:2], wdata[31:0], wstrb[3:0]}.
- One combinational sub-module, store_align_rv32i: (addr[1:0], store_type, req_data) → (wdata, wstrb, misaligned).
- The FIFO storage and pointers stay inline in store_unit_rv32i.

## Test plan
- Reset, then SB addr=0x1003 data=0x000000AB with dmem_ready=1 → next cycle dmem_valid=1, dmem_addr=0x1000, wdata=0xAB000000, wstrb=1000. Dequeued that cycle; idle=1 afterwards.
- SH addr=0x2002 data=0x1234BEEF → wdata=0xBEEF0000, wstrb=1100. Then SW addr=0x2004 data=0xCAFEF00D → wdata=0xCAFEF00D, wstrb=1111, in order.
- SH addr=0x3001 and SW addr=0x3002 → each handshaken, misalign pulses one cycle each, no dmem_valid, idle stays 1.
- dmem_ready=0, issue 3 SW stores back-to-back → first two accepted, req_ready=0 on the third. Payload holds stable. Raise dmem_ready → third accepted one cycle after the first dequeue, and drain order is 1, 2, 3.
- Buffer holding 1 entry with dmem_ready=1 and a new legal request in the same cycle → count stays 1, dmem_valid stays 1 with the new entry.
- Assert rst asynchronously with 2 entries pending → dmem_valid=0 and idle=1 before the next clock edge. The old stores are never issued after rst is released.
